// File: rtl/signed_mul8_seq_pkg.sv
// Shared types and helpers for the sequential signed shift-add multiplier.
// Holds the FSM state encoding, the default signed range constants and the
// range check that decides overflow.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed range of the default 8-bit configuration.
  localparam int SMAX8 = 127;
  localparam int SMIN8 = -128;

  // Largest value representable in w signed bits.
  function automatic int smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in w signed bits.
  function automatic int smin(input int w);
    return -(1 << (w - 1));
  endfunction

  // True when v fits in a w-bit two's-complement value.
  // The 32-bit argument holds the full product for any width up to 16.
  function automatic logic in_srange(input logic signed [31:0] v, input int w);
    return (v >= smin(w)) && (v <= smax(w));
  endfunction

endpackage

// File: rtl/mul_datapath_shift_add.sv
// Shift-and-add datapath: operand magnitudes, accumulator and iteration
// counter. Sequencing comes from the FSM in signed_mul8_seq via load_i/step_i.
module mul_datapath_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               sign_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_q, sign_d;

  // Magnitude one bit wider than the operand so that the most negative
  // value (-2^(WIDTH-1)) has a representable absolute value.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? (~ext + {{WIDTH{1'b0}}, 1'b1}) : ext;
  endfunction

  // Next-state: load fresh operands, or do one add/shift iteration.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    if (load_i) begin
      mcand_d  = {{(WIDTH-1){1'b0}}, mag(a_i)};
      mplier_d = mag(b_i);
      acc_d    = '0;
      cnt_d    = '0;
      sign_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Datapath state registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  assign acc_o  = acc_q;
  assign sign_o = sign_q;
  // Final iteration is the one stepping while the counter reads WIDTH-1.
  assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/signed_mul8_seq.sv
// Sequential signed WIDTH x WIDTH multiplier (no DSP), WIDTH iterations of
// shift-and-add. Returns the truncated product and an overflow flag.
// Optional build macro MUL_SATURATE_EN: on overflow, prod clamps to the
// signed max/min instead of wrapping.
module signed_mul8_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("signed_mul8_seq: WIDTH must be in 2..16");
  end

  state_e             state_q;
  logic               busy_q, done_q, ovf_q;
  logic [WIDTH-1:0]   prod_q;

  logic               load, step, last, sign;
  logic [2*WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0] full;
  logic signed [31:0] full32;
  logic               ovf_d;
  logic [WIDTH-1:0]   prod_d;

  assign load = (state_q == IDLE) && start;
  assign step = (state_q == RUN);

  mul_datapath_shift_add #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .a_i    (a),
    .b_i    (b),
    .acc_o  (acc),
    .sign_o (sign),
    .last_o (last)
  );

  // Reapply the sign to the magnitude product; -0 stays 0.
  assign full   = sign ? -$signed(acc) : $signed(acc);
  assign full32 = 32'(full);
  assign ovf_d  = !in_srange(full32, WIDTH);

  // Result selection: wrapped low bits, or clamped when saturation is built in.
  always_comb begin
    prod_d = full[WIDTH-1:0];
`ifdef MUL_SATURATE_EN
    if (ovf_d) prod_d = sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (last) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          prod_q  <= prod_d;
          ovf_q   <= ovf_d;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign prod = prod_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_signed_mul8_seq.sv
// Self-checking bench for signed_mul8_seq: directed test-plan cases with
// literal expectations, handshake/reset scenarios, then random operands
// checked against a plain-arithmetic product model.
module tb_signed_mul8_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, ovf;
  logic [W-1:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_mul8_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, then wrap or clamp.
  function automatic void model(input int x, input int y, output logic [W-1:0] p, output logic o);
    longint f, lo, hi;
    f  = longint'(x) * longint'(y);
    lo = -(longint'(1) << (W - 1));
    hi = (longint'(1) << (W - 1)) - 1;
    o  = (f < lo) || (f > hi);
    p  = f[W-1:0];
`ifdef MUL_SATURATE_EN
    if (o) p = (f < 0) ? lo[W-1:0] : hi[W-1:0];
`endif
  endfunction

  // Launch one job, wait for done within a bound, check latency and result.
  task automatic run_job(input int x, input int y, input logic [W-1:0] ep,
                         input logic eo, input string tag);
    int k;
    @(negedge clk);
    a = x[W-1:0];
    b = y[W-1:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".lat"}, k, W + 1);
    check({tag, ".prod"}, 32'(prod), 32'(ep));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  int           dx[10] = '{5, -7, 16, -16, -128, -128, -128, 0, -1, 20};
  int           dy[10] = '{6, 9, 8, 8, 1, -128, -1, -128, -1, -7};
`ifdef MUL_SATURATE_EN
  logic [W-1:0] dp[10] = '{8'd30, 8'hC1, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h00, 8'h01, 8'h80};
`else
  logic [W-1:0] dp[10] = '{8'd30, 8'hC1, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h00, 8'h01, 8'h74};
`endif
  logic         dovf[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic [W-1:0] ep;
    logic         eo;
    int           pulses, t0, t1, x, y, k;

    // Reset held while start is asserted: nothing may happen.
    a = 8'd5; b = 8'd6; start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.prod", 32'(prod), 0);
    check("rst.ovf",  32'(ovf), 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.busy", 32'(busy), 0);
    check("idle.done", 32'(done), 0);
    check("idle.prod", 32'(prod), 0);

    // Directed test-plan cases with literal expectations.
    for (int i = 0; i < 10; i++)
      run_job(dx[i], dy[i], dp[i], dovf[i], $sformatf("dir%0d", i));

    // Second request while busy is dropped.
    @(negedge clk);
    a = 8'd3; b = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ign.pulses", pulses, 1);
    check("ign.prod", 32'(prod), 32'd12);

    // Held start relaunches: done pulses one product period apart.
    @(negedge clk);
    a = 8'd2; b = 8'd3; start = 1'b1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
    end
    start = 1'b0;
    check("hold.period", t1 - t0, W + 2);
    check("hold.prod", 32'(prod), 32'd6);
    repeat (15) @(negedge clk);

    // Reset four cycles into a job aborts it silently.
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 0);
    check("abort.done", 32'(done), 0);
    check("abort.prod", 32'(prod), 0);
    check("abort.ovf",  32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort.nodone", pulses, 0);
    check("abort.prod2", 32'(prod), 0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, 7));
      x = int'($urandom_range(0, 255)) - 128;
      y = int'($urandom_range(0, 255)) - 128;
      if (k == 0) x = -128;
      if (k == 1) y = 0;
      model(x, y, ep, eo);
      run_job(x, y, ep, eo, $sformatf("rnd%0d(%0d*%0d)", i, x, y));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
